sqrt_iter_unit: RTL and testbench

- Parametrised, sequential successor to the team's 16-bit digit-by-digit square-root datapath slice.
- Computes floor(sqrt(D)) of an unsigned WIDTH-bit radicand, two radicand bits per clock, using the shift / AND-3 / OR-1 recurrence.
- Holds its own iteration state, counter and start/busy/done handshake.
- Sits between the operand register file and the result bus of the arithmetic subsystem.

---
 rtl/sqrt_iter_unit.sv | 128 ++++++++++++
 tb/tb_sqrt_iter_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_unit.sv
// Sequential digit-by-digit integer square root: floor(sqrt(radicand)), two radicand bits per clock.
// Optional remainder output (radicand - root^2) enabled by defining SQRT_REM_EN.
module sqrt_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]     rem
`endif
);

  localparam int ROOT_W = WIDTH / 2;
  localparam int REM_W  = WIDTH / 2 + 1;
  localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    d_q, d_d;
  logic [REM_W-1:0]    r_q, r_d;
  logic [ROOT_W-1:0]   q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROOT_W-1:0]   root_q, root_d;
`ifdef SQRT_REM_EN
  logic [REM_W-1:0]    rem_q, rem_d;
`endif

  // One recurrence step; rn/t carry headroom so the compare never truncates.
  logic [1:0]          digit;
  logic [REM_W+1:0]    rn;
  logic [REM_W+1:0]    t;
  logic                ge;
  logic [REM_W-1:0]    r_step;
  logic [ROOT_W-1:0]   q_step;

  always_comb begin
    digit  = 2'(d_q >> {cnt_q, 1'b0});
    rn     = {r_q, digit};
    t      = (REM_W + 2)'({q_q, 2'b01});
    ge     = (rn >= t);
    r_step = ge ? REM_W'(rn - t) : REM_W'(rn);
    q_step = {q_q[ROOT_W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
`ifdef SQRT_REM_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = radicand;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(ROOT_W - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          root_d  = q_step;
`ifdef SQRT_REM_EN
          rem_d   = r_step;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
`ifdef SQRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
`ifdef SQRT_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign root = root_q;
`ifdef SQRT_REM_EN
  assign rem  = rem_q;
`endif

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Self-checking bench for sqrt_iter_unit (WIDTH=16 and WIDTH=32 instances), scoreboard-driven.
module tb_sqrt_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] radicand = '0;
  logic        busy, done;
  logic [7:0]  root;
  logic [8:0]  rem;

  logic        start32 = 1'b0;
  logic [31:0] rad32 = '0;
  logic        busy32, done32;
  logic [15:0] root32;
  logic [16:0] rem32;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] root;
    logic [8:0] rem;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sqrt_iter_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .radicand(radicand),
    .busy(busy), .done(done), .root(root)
`ifdef SQRT_REM_EN
    , .rem(rem)
`endif
  );

  sqrt_iter_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .radicand(rad32),
    .busy(busy32), .done(done32), .root(root32)
`ifdef SQRT_REM_EN
    , .rem(rem32)
`endif
  );

`ifndef SQRT_REM_EN
  assign rem   = '0;
  assign rem32 = '0;
`endif

  function automatic void model(input logic [15:0] d, output logic [7:0] r, output logic [8:0] m);
    longint unsigned x = 0;
    while ((x + 1) * (x + 1) <= longint'(d)) x++;
    r = 8'(x);
    m = 9'(longint'(d) - x * x);
  endfunction

  task automatic run_op(input logic [15:0] d, input logic [7:0] er, input logic [8:0] erem);
    exp_t e, got;
    logic [7:0] prev;
    int cyc = 0, nb = 0;
    bit seen = 0;
    e.root = er; e.rem = erem;
    sb.push_back(e);
    prev = root;
    @(negedge clk);
    start = 1'b1; radicand = d;
    @(posedge clk); #1;
    start = 1'b0; radicand = 16'($urandom);
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (root !== prev) begin
          failures++;
          $display("FAIL root_held d=%0d got=%0d want=%0d", d, root, prev);
        end
      end
      if (done) seen = 1;
      else if (busy) nb++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout d=%0d got=no_done want=done_within_20", d);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (cyc != 9) begin
      failures++;
      $display("FAIL latency d=%0d got=%0d want=9", d, cyc);
    end
    checks++;
    if (nb != 8) begin
      failures++;
      $display("FAIL busy_cycles d=%0d got=%0d want=8", d, nb);
    end
    got = sb.pop_front();
    checks++;
    if (root !== got.root) begin
      failures++;
      $display("FAIL root d=%0d got=%0d want=%0d", d, root, got.root);
    end
`ifdef SQRT_REM_EN
    checks++;
    if (rem !== got.rem) begin
      failures++;
      $display("FAIL rem d=%0d got=%0d want=%0d", d, rem, got.rem);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width d=%0d got=%b want=0", d, done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, root, rem} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b/%b/%0d/%0d want=0/0/0/0", busy, done, root, rem);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(16'd144,   8'd12,  9'd0);
    run_op(16'd145,   8'd12,  9'd1);
    run_op(16'd0,     8'd0,   9'd0);
    run_op(16'hFFFF,  8'd255, 9'd510);
    run_op(16'h0001,  8'd1,   9'd0);
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [7:0]  er;
    logic [8:0]  em;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom_range(0, 65535));
      model(d, er, em);
      run_op(d, er, em);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc = 0, extra = 0;
    bit seen = 0;
    e.root = 8'd10; e.rem = 9'd0;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; radicand = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; radicand = 16'd49;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 3;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || cyc != 9) begin
      failures++;
      $display("FAIL b2b_latency got=%0d want=9", cyc);
    end
    e = sb.pop_front();
    checks++;
    if (root !== e.root) begin
      failures++;
      $display("FAIL b2b_root got=%0d want=%0d", root, e.root);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL b2b_extra_done got=%0d want=0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int spurious = 0;
    @(negedge clk);
    start = 1'b1; radicand = 16'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, root} !== '0) begin
      failures++;
      $display("FAIL mid_reset_state got=%b/%b/%0d want=0/0/0", busy, done, root);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL mid_reset_no_done got=%0d want=0", spurious);
    end
    run_op(16'd81, 8'd9, 9'd0);
  endtask

  task automatic test_width32();
    int cyc = 0;
    bit seen = 0;
    @(negedge clk);
    start32 = 1'b1; rad32 = 32'hFFFE0001;
    @(posedge clk); #1;
    start32 = 1'b0; rad32 = '0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done32) seen = 1;
    end
    checks++;
    if (!seen || cyc != 17) begin
      failures++;
      $display("FAIL w32_latency got=%0d want=17", cyc);
    end
    checks++;
    if (root32 !== 16'd65535) begin
      failures++;
      $display("FAIL w32_root got=%0d want=65535", root32);
    end
`ifdef SQRT_REM_EN
    checks++;
    if (rem32 !== 17'd0) begin
      failures++;
      $display("FAIL w32_rem got=%0d want=0", rem32);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_width32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
